if_queue: RTL and testbench

IF_QUEUE -- requirements
Module: if_queue

---
 rtl/if_queue_pkg.sv | 16 +
 rtl/if_queue.sv | 83 ++++++++
 tb/tb_if_queue.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_queue_pkg.sv
// Shared definitions for the instruction queue between fetch and decode.
// Holds the datapath width, the NOP encoding shown when the queue is empty,
// and the packed {inst, pc} entry type stored in the queue.
package if_queue_pkg;

  localparam int XLEN_WIDTH = 32;

  // addi x0, x0, 0 -- presented to decode whenever nothing valid is queued
  localparam logic [XLEN_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_WIDTH-1:0] inst;
    logic [XLEN_WIDTH-1:0] pc;
  } entry_t;

endpackage

// File: rtl/if_queue.sv
// Purpose: first-word-fall-through queue of {inst, pc} pairs from fetch to decode.
// Latency: a pushed entry reaches out_* one cycle after its push edge; no same-cycle bypass.
// Backpressure: in_ready = not full (registered state only); a pop never frees a slot in the same cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_inst/in_pc    : fetch side handshake and payload
//   flush                              : redirect, empties the queue, beats push and pop
//   out_valid/out_ready/out_inst/out_pc: decode side handshake and head payload
//   count                              : occupancy 0..DEPTH
module if_queue
  import if_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN_WIDTH-1:0]   in_inst,
  input  logic [XLEN_WIDTH-1:0]   in_pc,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN_WIDTH-1:0]   out_inst,
  output logic [XLEN_WIDTH-1:0]   out_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("if_queue: DEPTH must be a power of two between 2 and 16");
  end

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  // Full/empty come straight from the occupancy register, so the ready
  // path back to fetch never sees out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    out_inst = INST_NOP;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = mem[rd_ptr].inst;
      out_pc   = mem[rd_ptr].pc;
    end
  end

  // Pointers wrap naturally: DEPTH is a power of two and they are PW bits wide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
  end

endmodule

// File: tb/tb_if_queue.sv
module tb_if_queue;
  import if_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int total;
  int bad;

  if_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one clock edge, land 1 time unit after it for sampling.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_pc     = pc;
    in_inst   = mk_inst(pc);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input int exp_cnt, input logic [31:0] exp_pc);
    chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_cnt != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_cnt != DEPTH));
    if (exp_cnt != 0) begin
      chk({tag, ".out_pc"}, out_pc, exp_pc);
      chk({tag, ".out_inst"}, out_inst, mk_inst(exp_pc));
    end else begin
      chk({tag, ".out_pc"}, out_pc, 32'h0);
      chk({tag, ".out_inst"}, out_inst, 32'h0000_0013);
    end
  endtask

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    int          cnt;   // expected occupancy after the edge
    logic [31:0] opc;   // expected head pc after the edge (ignored when empty)
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } pair_t;

  initial begin
    vec_t  tbl [15];
    pair_t q [$];

    total = 0;
    bad   = 0;

    // Fill 4, offer a fifth while full, drain in order, then corner cases:
    // pop while empty, push+pop at count 1, flush with push and pop offered.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h04, 2, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h08, 3, 32'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0C, 4, 32'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 4, 32'h00};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h14, 3, 32'h04};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h18, 2, 32'h08};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 1, 32'h0C};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 0, 32'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h1C, 0, 32'h00};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h20, 1, 32'h20};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h24, 1, 32'h24};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h28, 2, 32'h24};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 32'h2C, 0, 32'h00};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 32'h30, 0, 32'h00};

    rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = '0; in_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_head("reset", 0, 32'h0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk_head("idle", 0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].pc);
      chk_head($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].opc);
    end

    // Steady push+pop at count 2 across several pointer wraps.
    step(1'b1, 1'b0, 1'b0, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h104);
    chk_head("steady.fill", 2, 32'h100);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h108 + 32'(4 * k));
      chk_head($sformatf("steady%0d", k), 2, 32'h100 + 32'(4 * (k + 1)));
    end

    // Flush from count 3 with a push and pop offered in the same cycle.
    step(1'b1, 1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, 32'h300);
    step(1'b1, 1'b0, 1'b0, 32'h304);
    step(1'b1, 1'b0, 1'b0, 32'h308);
    chk_head("flush.pre", 3, 32'h300);
    step(1'b1, 1'b1, 1'b1, 32'h30C);
    chk_head("flush.post", 0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_head("flush.idle", 0, 32'h0);

    // Asynchronous reset between edges with two entries queued.
    step(1'b1, 1'b0, 1'b0, 32'h400);
    step(1'b1, 1'b0, 1'b0, 32'h404);
    in_valid = 1'b0;
    chk_head("arst.pre", 2, 32'h400);
    #3 rst = 1'b0;
    #1;
    chk_head("arst.mid", 0, 32'h0);
    #2 rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk_head("arst.after", 0, 32'h0);

    // Random traffic against a queue model; bias flips every 1000 cycles so
    // the queue spends time both near full and near empty.
    for (int n = 0; n < 10000; n++) begin
      logic iv, ordy, fl;
      logic [31:0] pc, inst;
      logic do_push, do_pop;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((n / 1000) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 63) == 0);
      pc   = $urandom;
      inst = $urandom;
      do_push = iv && (q.size() < DEPTH) && !fl;
      do_pop  = ordy && (q.size() > 0) && !fl;
      in_valid = iv; out_ready = ordy; flush = fl; in_pc = pc; in_inst = inst;
      @(posedge clk);
      #1;
      if (fl) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back('{inst, pc});
      end
      chk("rnd.count", 32'(count), 32'(q.size()));
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd.in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      if (q.size() != 0) begin
        chk("rnd.out_pc", out_pc, q[0].pc);
        chk("rnd.out_inst", out_inst, q[0].inst);
      end else begin
        chk("rnd.out_inst", out_inst, 32'h0000_0013);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
